// File: rtl/slave_burst_sequencer_if.sv
// Bundles the arbiter/FIFO-side inputs and the slave-side outputs of slave_burst_sequencer.
// The "slave" modport is the sequencer's view; "master" is the driving environment's view.
interface slave_burst_sequencer_if #(
  parameter int masters   = 2,
  parameter int slaves    = 2,
  parameter int max_beats = 16
);
  localparam int MW = (masters > 1) ? $clog2(masters) : 1;
  localparam int DW = (slaves > 1) ? $clog2(slaves) : 1;
  localparam int BW = $clog2(max_beats + 1);

  logic [masters-1:0] master_fifo_empty;
  logic [DW-1:0]      master_slave_dest [0:masters-1];
  logic [masters-1:0] master_fifo_last;
  logic [MW-1:0]      arb_grant_number;
  logic               slave_ready;
  logic               slave_valid;
  logic [MW-1:0]      sel_master;
  logic [masters-1:0] master_fifo_pop;
  logic               busy;
  logic [BW-1:0]      beat_count;
  logic               protocol_err;
  logic               timeout_pulse;

  modport slave (
    input  master_fifo_empty, master_slave_dest, master_fifo_last,
           arb_grant_number, slave_ready,
    output slave_valid, sel_master, master_fifo_pop, busy,
           beat_count, protocol_err, timeout_pulse
  );

  modport master (
    output master_fifo_empty, master_slave_dest, master_fifo_last,
           arb_grant_number, slave_ready,
    input  slave_valid, sel_master, master_fifo_pop, busy,
           beat_count, protocol_err, timeout_pulse
  );
endinterface

// File: rtl/slave_burst_sequencer.sv
// Per-slave burst sequencer: locks the slave port to the granted master for a whole burst.
// Optional stall watchdog enabled by defining SLAVE_BURST_SEQUENCER_WATCHDOG_EN.
module slave_burst_sequencer #(
  parameter int masters           = 2,
  parameter int slaves            = 2,
  parameter int i_am_slave_number = 0,
  parameter int max_beats         = 16,
  parameter int timeout_cycles    = 64
) (
  input logic                  ACLK,
  input logic                  ARESETn,
  slave_burst_sequencer_if.slave bus
);
  localparam int MW = (masters > 1) ? $clog2(masters) : 1;
  localparam int DW = (slaves > 1) ? $clog2(slaves) : 1;
  localparam int BW = $clog2(max_beats + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t             state, state_nxt;
  logic [MW-1:0]      sel_q;
  logic [BW-1:0]      cnt_q;
  logic               err_q;
  logic [masters-1:0] req_me;
  logic               latch;
  logic               accept;
  logic               valid;
  logic [masters-1:0] pop;
  logic               stalled;
  logic               tpulse;

  always_comb begin
    for (int unsigned i = 0; i < masters; i++) begin
      req_me[i] = ~bus.master_fifo_empty[i] &
                  (bus.master_slave_dest[i] == DW'(i_am_slave_number));
    end
  end

`ifdef SLAVE_BURST_SEQUENCER_WATCHDOG_EN
  localparam int TW = $clog2(timeout_cycles + 1);
  logic [TW-1:0] wd_q;
  logic          wd_fire;

  assign wd_fire = (state == LOCK) && stalled && (wd_q == TW'(timeout_cycles - 1));

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wd_q <= '0;
    end else if (latch || accept) begin
      wd_q <= '0;
    end else if (state == LOCK && stalled) begin
      wd_q <= wd_q + 1'b1;
    end
  end
`else
  logic wd_fire;
  assign wd_fire = 1'b0;
`endif

  assign stalled = bus.master_fifo_empty[sel_q];

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    accept    = 1'b0;
    valid     = 1'b0;
    pop       = '0;
    tpulse    = 1'b0;
    case (state)
      IDLE: begin
        if ((int'(bus.arb_grant_number) < masters) && req_me[bus.arb_grant_number]) begin
          latch     = 1'b1;
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        // Destination is not re-checked here: the burst is already committed.
        valid  = ~stalled;
        accept = valid & bus.slave_ready;
        if (accept) begin
          pop[sel_q] = 1'b1;
          if (bus.master_fifo_last[sel_q] || (cnt_q == BW'(max_beats - 1))) begin
            state_nxt = IDLE;
          end
        end
        if (wd_fire) begin
          tpulse    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state <= IDLE;
      sel_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (latch) begin
        sel_q <= bus.arb_grant_number;
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 1'b1;
        if (!bus.master_fifo_last[sel_q] && (cnt_q == BW'(max_beats - 1))) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.slave_valid     = valid;
  assign bus.master_fifo_pop = pop;
  assign bus.busy            = (state == LOCK);
  assign bus.sel_master      = sel_q;
  assign bus.beat_count      = cnt_q;
  assign bus.protocol_err    = err_q;
  assign bus.timeout_pulse   = tpulse;
endmodule

// File: tb/tb_slave_burst_sequencer.sv
// Randomized bench for slave_burst_sequencer checked against a burst-level reference model.
module tb_slave_burst_sequencer;
  localparam int M  = 2;
  localparam int S  = 2;
  localparam int MB = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  slave_burst_sequencer_if #(.masters(M), .slaves(S), .max_beats(MB)) bus ();

  slave_burst_sequencer #(
    .masters(M), .slaves(S), .i_am_slave_number(0),
    .max_beats(MB), .timeout_cycles(TO)
  ) dut (
    .ACLK(clk),
    .ARESETn(rstn),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: owner<0 means no burst owns the port.
  int owner = -1;
  int sel   = 0;
  int beats = 0;
  int stall = 0;
  bit err   = 1'b0;

  initial begin
    int ebusy, evalid, eacc, epop, etp, g, last_pct;
    rstn = 1'b0;
    bus.master_fifo_empty = '1;
    bus.master_fifo_last  = '0;
    bus.arb_grant_number  = '0;
    bus.slave_ready       = 1'b0;
    for (int i = 0; i < M; i++) bus.master_slave_dest[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy",  32'(bus.busy), 0);
    check_val("rst_valid", 32'(bus.slave_valid), 0);
    check_val("rst_pop",   32'(bus.master_fifo_pop), 0);
    check_val("rst_sel",   32'(bus.sel_master), 0);
    check_val("rst_beats", 32'(bus.beat_count), 0);
    check_val("rst_err",   32'(bus.protocol_err), 0);
    check_val("rst_tp",    32'(bus.timeout_pulse), 0);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      // Vary burst length and stall density across phases.
      last_pct = (cyc < 1500) ? 35 : (cyc < 2800 ? 8 : 20);
      rstn = (cyc == 0) ? 1'b1 : ($urandom_range(0, 149) != 0);
      for (int i = 0; i < M; i++) begin
        if (cyc >= 2800 && owner >= 0 && i == sel)
          bus.master_fifo_empty[i] = ($urandom_range(0, 9) != 0);
        else
          bus.master_fifo_empty[i] = ($urandom_range(0, 3) == 0);
        bus.master_slave_dest[i] = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
        bus.master_fifo_last[i]  = ($urandom_range(0, 99) < last_pct);
      end
      bus.arb_grant_number = 1'($urandom_range(0, M - 1));
      bus.slave_ready      = ($urandom_range(0, 3) != 0);
      #1;

      ebusy  = (owner >= 0) ? 1 : 0;
      evalid = (ebusy == 1 && !bus.master_fifo_empty[sel]) ? 1 : 0;
      eacc   = (evalid == 1 && bus.slave_ready) ? 1 : 0;
      epop   = (eacc == 1) ? (1 << sel) : 0;
`ifdef SLAVE_BURST_SEQUENCER_WATCHDOG_EN
      etp    = (ebusy == 1 && bus.master_fifo_empty[sel] && stall == TO - 1) ? 1 : 0;
`else
      etp    = 0;
`endif
      check_val("busy",  32'(bus.busy), 32'(ebusy));
      check_val("valid", 32'(bus.slave_valid), 32'(evalid));
      check_val("pop",   32'(bus.master_fifo_pop), 32'(epop));
      check_val("sel",   32'(bus.sel_master), 32'(sel));
      check_val("beats", 32'(bus.beat_count), 32'(beats));
      check_val("err",   32'(bus.protocol_err), 32'(err));
      check_val("tp",    32'(bus.timeout_pulse), 32'(etp));

      if (!rstn) begin
        owner = -1; sel = 0; beats = 0; stall = 0; err = 1'b0;
      end else if (owner < 0) begin
        g = int'(bus.arb_grant_number);
        if (!bus.master_fifo_empty[g] && bus.master_slave_dest[g] == 0) begin
          owner = g; sel = g; beats = 0; stall = 0;
        end
      end else if (eacc == 1) begin
        stall = 0;
        beats++;
        if (bus.master_fifo_last[sel]) owner = -1;
        else if (beats == MB) begin
          err = 1'b1;
          owner = -1;
        end
      end else if (bus.master_fifo_empty[sel]) begin
        if (etp == 1) owner = -1;
        stall++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
